// File: rtl/bypass_scoreboard_pkg.sv
// bypass_scoreboard_pkg
//   Shared constants for the bypass scoreboard and its per-port selector:
//   parameter defaults, slot field widths, the hard-wired zero register and
//   the pipeline stage indices that the slot numbering follows.
package bypass_scoreboard_pkg;

  // Stage indices; slot k of the scoreboard mirrors pipeline stage k
  localparam int STAGE_EX  = 0;
  localparam int STAGE_MEM = 1;
  localparam int STAGE_WB  = 2;

  // Parameter defaults for bypass_scoreboard
  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_ADDR_W     = 5;
  localparam int DEFAULT_NUM_RD     = 2;
  localparam int DEFAULT_DEPTH      = STAGE_WB + 1;
  localparam int DEFAULT_LOAD_STAGE = STAGE_MEM;
  localparam int DEFAULT_CNT_W      = 16;

  // Register 0 is hard-wired to zero: it is never forwarded or written back
  localparam int REG_ZERO = 0;

  // Slot flags: valid, we, isLoad, rdy (one bit each)
  localparam int SLOT_FLAG_W = 4;

  // Total bits held by one slot (flags + destination + data)
  function automatic int slotWidth(input int dataW, input int addrW);
    return SLOT_FLAG_W + addrW + dataW;
  endfunction

endpackage

// File: rtl/bypass_select.sv
// bypass_select
//   Forwarding selector for one read port. Finds the youngest (lowest index)
//   slot whose destination matches the port's source register and reports
//   whether it hit, whether that producer's data is ready, and the data.
//
// Ports:
//   slotValid/slotWe/slotRdy  in  DEPTH           per-slot flags
//   slotRd                    in  DEPTH x ADDR_W  per-slot destination
//   slotData                  in  DEPTH x DATA_W  per-slot result
//   rdEn                      in  1               port read enable
//   rdAddr                    in  ADDR_W          port source register
//   hit                       out 1               some slot matches
//   rdy                       out 1               youngest match has data
//   data                      out DATA_W          youngest match's data
module bypass_select
  import bypass_scoreboard_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic [DEPTH-1:0]             slotValid,
  input  logic [DEPTH-1:0]             slotWe,
  input  logic [DEPTH-1:0]             slotRdy,
  input  logic [DEPTH-1:0][ADDR_W-1:0] slotRd,
  input  logic [DEPTH-1:0][DATA_W-1:0] slotData,
  input  logic                         rdEn,
  input  logic [ADDR_W-1:0]            rdAddr,
  output logic                         hit,
  output logic                         rdy,
  output logic [DATA_W-1:0]            data
);

  logic [DEPTH-1:0] match;

  // A slot matches when it will write this port's source register;
  // register 0 is excluded so a write to r0 can never be forwarded.
  always_comb begin
    match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match[k] = slotValid[k] & slotWe[k] & rdEn
               & (slotRd[k] != ADDR_W'(REG_ZERO))
               & (slotRd[k] == rdAddr);
    end
  end

  // Priority encoder: scanning oldest to youngest lets the youngest match
  // overwrite any older one, so an unready young producer is never masked
  // by an older ready one.
  always_comb begin
    hit  = 1'b0;
    rdy  = 1'b0;
    data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit  = 1'b1;
        rdy  = slotRdy[k];
        data = slotData[k];
      end
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard
//   Tracks in-flight register writes over DEPTH pipeline slots (slot 0 = EX,
//   slot DEPTH-1 = WB), forwards the youngest ready producer to each of
//   NUM_RD read ports, and raises stall when the youngest producer is a load
//   whose data has not arrived. The last slot drives the register-file write
//   port. LOAD_STAGE must be less than DEPTH-1.
//
// Ports:
//   clk, rst_n          in   clock, synchronous active-low reset
//   freeze              in   hold every slot (no shift, no load capture)
//   in_valid/in_we      in   instruction entering slot 0, writes a register
//   in_rd/in_is_load    in   destination, result comes from memory
//   in_data             in   ALU result (ignored for loads)
//   ld_data             in   load data for the load in slot LOAD_STAGE
//   rd_en/rd_addr       in   per-port read enable and packed source regs
//   rf_data             in   packed register-file read data
//   out_data            out  packed forwarded operands
//   stall               out  load-use hazard
//   wb_we/wb_rd/wb_data out  register-file write port
//   stall_cnt           out  saturating count of stalled cycles
module bypass_scoreboard
  import bypass_scoreboard_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int NUM_RD     = DEFAULT_NUM_RD,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int LOAD_STAGE = DEFAULT_LOAD_STAGE,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     freeze,
  input  logic                     in_valid,
  input  logic                     in_we,
  input  logic [ADDR_W-1:0]        in_rd,
  input  logic                     in_is_load,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] rf_data,
  output logic [NUM_RD*DATA_W-1:0] out_data,
  output logic                     stall,
  output logic                     wb_we,
  output logic [ADDR_W-1:0]        wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic [DEPTH-1:0]             slotValid;
  logic [DEPTH-1:0]             slotWe;
  logic [DEPTH-1:0]             slotRdy;
  logic [DEPTH-1:0][ADDR_W-1:0] slotRd;
  logic [DEPTH-1:0][DATA_W-1:0] slotData;
  // Only slots up to LOAD_STAGE need to remember a pending load; past that
  // point the data has been captured and rdy says everything.
  logic [LOAD_STAGE:0]          slotIsLoad;
  logic [CNT_W-1:0]             stallCnt;

  logic loadCapture;
  assign loadCapture = slotValid[LOAD_STAGE] & slotIsLoad[LOAD_STAGE];

  // Control state: valid/rdy shift with the pipeline, and a load leaving
  // LOAD_STAGE becomes ready in the next slot. The stall counter keeps
  // counting while frozen because a frozen stall is still a lost cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slotValid  <= '0;
      slotRdy    <= '0;
      slotIsLoad <= '0;
      stallCnt   <= '0;
    end else begin
      if (stall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
      if (!freeze) begin
        slotValid <= {slotValid[DEPTH-2:0], in_valid};
        slotRdy   <= {slotRdy[DEPTH-2:0], ~in_is_load};
        for (int k = LOAD_STAGE; k > 0; k--) begin
          slotIsLoad[k] <= slotIsLoad[k-1];
        end
        slotIsLoad[0] <= in_is_load;
        if (loadCapture) begin
          slotRdy[LOAD_STAGE+1] <= 1'b1;
        end
      end
    end
  end

  // Datapath fields need no reset: nothing reads them while valid is low.
  always_ff @(posedge clk) begin
    if (!freeze) begin
      slotWe   <= {slotWe[DEPTH-2:0], in_we};
      slotRd   <= {slotRd[DEPTH-2:0], in_rd};
      slotData <= {slotData[DEPTH-2:0], in_data};
      if (loadCapture) begin
        slotData[LOAD_STAGE+1] <= ld_data;
      end
    end
  end

  assign wb_we     = slotValid[DEPTH-1] & slotWe[DEPTH-1]
                   & (slotRd[DEPTH-1] != ADDR_W'(REG_ZERO));
  assign wb_rd     = slotRd[DEPTH-1];
  assign wb_data   = slotData[DEPTH-1];
  assign stall_cnt = stallCnt;

  logic [NUM_RD-1:0]             portHit;
  logic [NUM_RD-1:0]             portRdy;
  logic [NUM_RD-1:0][DATA_W-1:0] portData;

  for (genvar i = 0; i < NUM_RD; i++) begin : gPort
    bypass_select #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) uSelect (
      .slotValid (slotValid),
      .slotWe    (slotWe),
      .slotRdy   (slotRdy),
      .slotRd    (slotRd),
      .slotData  (slotData),
      .rdEn      (rd_en[i]),
      .rdAddr    (rd_addr[i*ADDR_W +: ADDR_W]),
      .hit       (portHit[i]),
      .rdy       (portRdy[i]),
      .data      (portData[i])
    );

    // An unready hit falls back to rf_data; stall tells decode not to use it
    assign out_data[i*DATA_W +: DATA_W] = (portHit[i] & portRdy[i]) ?
                                          portData[i] :
                                          rf_data[i*DATA_W +: DATA_W];
  end

  assign stall = |(portHit & ~portRdy);

endmodule

// File: tb/tb_bypass_scoreboard.sv
// tb_bypass_scoreboard
//   Directed, table-driven bench. Each record gives the inputs for one cycle
//   and the combinational outputs expected during that cycle (before the
//   edge that commits it). A second instance with CNT_W=2 shows saturation.
module tb_bypass_scoreboard;

  localparam logic [31:0] RF0 = 32'h11;
  localparam logic [31:0] RF1 = 32'h22;

  typedef struct {
    string       name;
    logic        rstN;
    logic        freeze;
    logic        inValid;
    logic        inWe;
    logic [4:0]  inRd;
    logic        inIsLoad;
    logic [31:0] inData;
    logic [31:0] ldData;
    logic [1:0]  rdEn;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        expStall;
    logic        expWbWe;
    logic [4:0]  expWbRd;
    logic [31:0] expWbData;
    int          expCnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, freeze, in_valid, in_we, in_is_load;
  logic [4:0]  in_rd;
  logic [31:0] in_data, ld_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rf_data;
  logic [63:0] out_data, outDataS;
  logic        stall, wb_we, stallS, wbWeS;
  logic [4:0]  wb_rd, wbRdS;
  logic [31:0] wb_data, wbDataS;
  logic [15:0] stall_cnt;
  logic [1:0]  stallCntS;

  int compared   = 0;
  int mismatched = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  bypass_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .in_valid(in_valid),
    .in_we(in_we), .in_rd(in_rd), .in_is_load(in_is_load),
    .in_data(in_data), .ld_data(ld_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rf_data(rf_data), .out_data(out_data),
    .stall(stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_cnt(stall_cnt)
  );

  bypass_scoreboard #(.CNT_W(2)) dutSmall (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .in_valid(in_valid),
    .in_we(in_we), .in_rd(in_rd), .in_is_load(in_is_load),
    .in_data(in_data), .ld_data(ld_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rf_data(rf_data), .out_data(outDataS),
    .stall(stallS), .wb_we(wbWeS), .wb_rd(wbRdS), .wb_data(wbDataS),
    .stall_cnt(stallCntS)
  );

  function automatic vec_t mkVec(
    input string name, input bit rstN, input bit frz, input bit v,
    input bit we, input int rd, input bit ld, input logic [31:0] d,
    input logic [31:0] ldD, input logic [1:0] en, input int a0, input int a1,
    input logic [31:0] e0, input logic [31:0] e1, input bit st,
    input bit wbWe, input int wbRd, input logic [31:0] wbD, input int cnt);
    vec_t r;
    r.name = name;  r.rstN = rstN;  r.freeze = frz;  r.inValid = v;
    r.inWe = we;    r.inRd = rd[4:0]; r.inIsLoad = ld; r.inData = d;
    r.ldData = ldD; r.rdEn = en;    r.ra0 = a0[4:0]; r.ra1 = a1[4:0];
    r.exp0 = e0;    r.exp1 = e1;    r.expStall = st; r.expWbWe = wbWe;
    r.expWbRd = wbRd[4:0]; r.expWbData = wbD; r.expCnt = cnt;
    return r;
  endfunction

  task automatic cmp(input string name, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h", name, what, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    int smallCnt;
    smallCnt = (v.expCnt > 3) ? 3 : v.expCnt;
    cmp(v.name, "out0", out_data[31:0], v.exp0);
    cmp(v.name, "out1", out_data[63:32], v.exp1);
    cmp(v.name, "stall", {31'b0, stall}, {31'b0, v.expStall});
    cmp(v.name, "wbWe", {31'b0, wb_we}, {31'b0, v.expWbWe});
    if (v.expWbWe) begin
      cmp(v.name, "wbRd", {27'b0, wb_rd}, {27'b0, v.expWbRd});
      cmp(v.name, "wbData", wb_data, v.expWbData);
    end
    cmp(v.name, "stallCnt", {16'b0, stall_cnt}, v.expCnt);
    cmp(v.name, "stallCntSat", {30'b0, stallCntS}, smallCnt);
  endtask

  // Drive on the falling edge, check 1ns later; the next rising edge commits
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n      = v.rstN;
    freeze     = v.freeze;
    in_valid   = v.inValid;
    in_we      = v.inWe;
    in_rd      = v.inRd;
    in_is_load = v.inIsLoad;
    in_data    = v.inData;
    ld_data    = v.ldData;
    rd_en      = v.rdEn;
    rd_addr    = {v.ra1, v.ra0};
    rf_data    = {RF1, RF0};
    #1;
    checkOutput(v);
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0; in_valid = 1'b0; in_we = 1'b0;
    in_rd = '0; in_is_load = 1'b0; in_data = '0; ld_data = '0;
    rd_en = '0; rd_addr = '0; rf_data = {RF1, RF0};
    repeat (2) @(posedge clk);

    //                  name           rst frz v we rd ld data      ldData    en a0 a1 exp0      exp1 st wb rd wbData    cnt
    vecs.push_back(mkVec("reset",        1, 0, 0, 0, 0, 0, 0,        0,        3, 5, 6, RF0,      RF1, 0, 0, 0, 0,        0));
    vecs.push_back(mkVec("aluEnter",     1, 0, 1, 1, 5, 0, 'hAAAA,   0,        3, 5, 6, RF0,      RF1, 0, 0, 0, 0,        0));
    vecs.push_back(mkVec("aluEx",        1, 0, 0, 0, 0, 0, 0,        0,        3, 5, 6, 'hAAAA,   RF1, 0, 0, 0, 0,        0));
    vecs.push_back(mkVec("aluMem",       1, 0, 0, 0, 0, 0, 0,        0,        3, 5, 6, 'hAAAA,   RF1, 0, 0, 0, 0,        0));
    vecs.push_back(mkVec("aluWb",        1, 0, 0, 0, 0, 0, 0,        0,        3, 5, 6, 'hAAAA,   RF1, 0, 1, 5, 'hAAAA,   0));
    vecs.push_back(mkVec("aluGone",      1, 0, 0, 0, 0, 0, 0,        0,        3, 5, 6, RF0,      RF1, 0, 0, 0, 0,        0));
    vecs.push_back(mkVec("youngEnter1",  1, 0, 1, 1, 5, 0, 1,        0,        3, 5, 6, RF0,      RF1, 0, 0, 0, 0,        0));
    vecs.push_back(mkVec("youngEnter2",  1, 0, 1, 1, 5, 0, 2,        0,        3, 5, 6, 1,        RF1, 0, 0, 0, 0,        0));
    vecs.push_back(mkVec("youngWins",    1, 0, 0, 0, 0, 0, 0,        0,        3, 5, 6, 2,        RF1, 0, 0, 0, 0,        0));
    vecs.push_back(mkVec("youngWinsWb",  1, 0, 0, 0, 0, 0, 0,        0,        3, 5, 6, 2,        RF1, 0, 1, 5, 1,        0));
    vecs.push_back(mkVec("port1Fwd",     1, 0, 0, 0, 0, 0, 0,        0,        3, 5, 5, 2,        2,   0, 1, 5, 2,        0));
    vecs.push_back(mkVec("loadEnter",    1, 0, 1, 1, 7, 1, 'h5555,   0,        0, 7, 6, RF0,      RF1, 0, 0, 0, 0,        0));
    vecs.push_back(mkVec("loadUseEx",    1, 0, 0, 0, 0, 0, 0,        0,        1, 7, 6, RF0,      RF1, 1, 0, 0, 0,        0));
    vecs.push_back(mkVec("loadUseMem",   1, 0, 0, 0, 0, 0, 0,        'hBEEF,   1, 7, 6, RF0,      RF1, 1, 0, 0, 0,        1));
    vecs.push_back(mkVec("loadFwd",      1, 0, 0, 0, 0, 0, 0,        0,        1, 7, 6, 'hBEEF,   RF1, 0, 1, 7, 'hBEEF,   2));
    vecs.push_back(mkVec("maskAlu",      1, 0, 1, 1, 8, 0, 'h88,     0,        1, 8, 6, RF0,      RF1, 0, 0, 0, 0,        2));
    vecs.push_back(mkVec("maskLoad",     1, 0, 1, 1, 8, 1, 0,        0,        1, 8, 6, 'h88,     RF1, 0, 0, 0, 0,        2));
    vecs.push_back(mkVec("maskYoungEx",  1, 0, 0, 0, 0, 0, 0,        0,        1, 8, 6, RF0,      RF1, 1, 0, 0, 0,        2));
    vecs.push_back(mkVec("maskYoungMem", 1, 0, 0, 0, 0, 0, 0,        'h1234,   1, 8, 6, RF0,      RF1, 1, 1, 8, 'h88,     3));
    vecs.push_back(mkVec("maskFwd",      1, 0, 0, 0, 0, 0, 0,        0,        1, 8, 6, 'h1234,   RF1, 0, 1, 8, 'h1234,   4));
    vecs.push_back(mkVec("r0Enter",      1, 0, 1, 1, 0, 0, 'hFFFF,   0,        3, 0, 6, RF0,      RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("r0Ex",         1, 0, 0, 0, 0, 0, 0,        0,        3, 0, 6, RF0,      RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("r0Mem",        1, 0, 0, 0, 0, 0, 0,        0,        3, 0, 6, RF0,      RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("r0Wb",         1, 0, 0, 0, 0, 0, 0,        0,        3, 0, 6, RF0,      RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("frzEnter",     1, 0, 1, 1, 9, 0, 'h99,     0,        3, 9, 10, RF0,     RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("frz1",         1, 1, 1, 1, 10, 0, 'h1010,  0,        3, 9, 10, 'h99,    RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("frz2",         1, 1, 0, 0, 0, 0, 0,        0,        3, 9, 10, 'h99,    RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("frz3",         1, 1, 0, 0, 0, 0, 0,        0,        3, 9, 10, 'h99,    RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("frzRelease",   1, 0, 0, 0, 0, 0, 0,        0,        3, 9, 10, 'h99,    RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("frzMem",       1, 0, 0, 0, 0, 0, 0,        0,        3, 9, 10, 'h99,    RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("frzWb",        1, 0, 0, 0, 0, 0, 0,        0,        3, 9, 10, 'h99,    RF1, 0, 1, 9, 'h99,     4));
    vecs.push_back(mkVec("satLoad",      1, 0, 1, 1, 11, 1, 0,       0,        0, 11, 6, RF0,     RF1, 0, 0, 0, 0,        4));
    vecs.push_back(mkVec("satFrz1",      1, 1, 0, 0, 0, 0, 0,        0,        1, 11, 6, RF0,     RF1, 1, 0, 0, 0,        4));
    vecs.push_back(mkVec("satFrz2",      1, 1, 0, 0, 0, 0, 0,        0,        1, 11, 6, RF0,     RF1, 1, 0, 0, 0,        5));
    vecs.push_back(mkVec("satFrz3",      1, 1, 0, 0, 0, 0, 0,        0,        1, 11, 6, RF0,     RF1, 1, 0, 0, 0,        6));
    vecs.push_back(mkVec("satRun",       1, 0, 0, 0, 0, 0, 0,        0,        1, 11, 6, RF0,     RF1, 1, 0, 0, 0,        7));
    vecs.push_back(mkVec("satMem",       1, 0, 0, 0, 0, 0, 0,        'hCAFE,   1, 11, 6, RF0,     RF1, 1, 0, 0, 0,        8));
    vecs.push_back(mkVec("satFwd",       1, 0, 0, 0, 0, 0, 0,        0,        1, 11, 6, 'hCAFE,  RF1, 0, 1, 11, 'hCAFE,  9));
    vecs.push_back(mkVec("rstLoad",      1, 0, 1, 1, 12, 1, 0,       0,        0, 13, 12, RF0,    RF1, 0, 0, 0, 0,        9));
    vecs.push_back(mkVec("rstAlu",       1, 0, 1, 1, 13, 0, 'h13,    0,        0, 13, 12, RF0,    RF1, 0, 0, 0, 0,        9));
    vecs.push_back(mkVec("rstEdge",      0, 0, 1, 1, 12, 0, 'h77,    0,        3, 13, 12, 'h13,   RF1, 1, 0, 0, 0,        9));
    vecs.push_back(mkVec("rstAfter1",    1, 0, 0, 0, 0, 0, 0,        0,        3, 13, 12, RF0,    RF1, 0, 0, 0, 0,        0));
    vecs.push_back(mkVec("rstAfter2",    1, 0, 0, 0, 0, 0, 0,        0,        3, 13, 12, RF0,    RF1, 0, 0, 0, 0,        0));

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset asserted together with freeze on a stalled load: reset must win,
    // clearing the pending load and blocking that edge's counter increment.
    $display("[TB] reset-over-freeze sequence");
    applyStimulus(mkVec("hLoad",   1, 0, 1, 1, 14, 1, 0, 0, 0, 14, 6, RF0, RF1, 0, 0, 0, 0, 0));
    applyStimulus(mkVec("hRstFrz", 0, 1, 0, 0, 0,  0, 0, 0, 1, 14, 6, RF0, RF1, 1, 0, 0, 0, 0));
    applyStimulus(mkVec("hAfter",  1, 1, 0, 0, 0,  0, 0, 0, 1, 14, 6, RF0, RF1, 0, 0, 0, 0, 0));
    applyStimulus(mkVec("hResume", 1, 0, 0, 0, 0,  0, 0, 0, 3, 14, 6, RF0, RF1, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
